// File: rtl/launcher_pkg.sv
// Shared types and default parameter values for the program launcher.
package launcher_pkg;
  localparam int DEF_PROG_W    = 2;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_RST_CYC   = 2;
  localparam int DEF_START_CYC = 1;
  localparam int DEF_TIMEOUT   = 1000;
  localparam int PHASE_W       = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    START  = 3'd2,
    ARM    = 3'd3,
    RUN    = 3'd4,
    REPORT = 3'd5,
    DONE   = 3'd6
  } launch_state_t;
endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; zero flags the last cycle of a CpuReset/CpuStart phase.
module phase_timer
  import launcher_pkg::*;
#(
  parameter int W = PHASE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) cnt_d = load_val;
    else if (cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/prog_launcher.sv
// Batch sequencer for the CPU Reset/Start/Ack handshake: launches each program,
// times the run until the CPU halts again, and reports one result per program.
module prog_launcher
  import launcher_pkg::*;
#(
  parameter int PROG_W    = DEF_PROG_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int RST_CYC   = DEF_RST_CYC,
  parameter int START_CYC = DEF_START_CYC,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Go,
  input  logic [PROG_W-1:0] LastProg,
  input  logic              Ack,
  output logic              CpuReset,
  output logic              CpuStart,
  output logic [PROG_W-1:0] ProgIdx,
  output logic              Busy,
  output logic              Done,
  output logic              ResValid,
  output logic [CNT_W-1:0]  ResCycles,
  output logic              ResTimeout,
  output logic [2:0]        DbgState
);
  localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [PHASE_W-1:0] RST_LD    = PHASE_W'(RST_CYC - 1);
  localparam logic [PHASE_W-1:0] START_LD  = PHASE_W'(START_CYC - 1);

  launch_state_t     state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d, count_inc;
  logic [PROG_W-1:0] last_q, last_d, prog_idx_q, prog_idx_d;
  logic [CNT_W-1:0]  res_cycles_q, res_cycles_d;
  logic              res_timeout_q, res_timeout_d;
  logic              cpu_reset_q, cpu_reset_d, cpu_start_q, cpu_start_d;
  logic              done_q, done_d, res_valid_q, res_valid_d;
  logic              tmr_load, tmr_zero;
  logic [PHASE_W-1:0] tmr_val;

  phase_timer #(.W(PHASE_W)) u_phase_timer (
    .clk      (Clk),
    .reset    (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    last_d        = last_q;
    prog_idx_d    = prog_idx_q;
    res_cycles_d  = res_cycles_q;
    res_timeout_d = res_timeout_q;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    case (state_q)
      IDLE, DONE: begin
        if (Go) begin
          last_d     = LastProg;
          prog_idx_d = '0;
          state_d    = RST;
          tmr_load   = 1'b1;
          tmr_val    = RST_LD;
        end
      end
      RST: begin
        if (tmr_zero) begin
          state_d  = START;
          tmr_load = 1'b1;
          tmr_val  = START_LD;
        end
      end
      START: begin
        if (tmr_zero) begin
          state_d = ARM;
          count_d = '0;
        end
      end
      // The exit condition is checked before the limit so a same-cycle exit wins.
      ARM: begin
        count_d = count_inc;
        if (!Ack) begin
          state_d = RUN;
        end else if (count_inc >= TIMEOUT_C) begin
          state_d       = REPORT;
          res_timeout_d = 1'b1;
          res_cycles_d  = TIMEOUT_C;
        end
      end
      RUN: begin
        count_d = count_inc;
        if (Ack) begin
          state_d       = REPORT;
          res_timeout_d = 1'b0;
          res_cycles_d  = count_inc;
        end else if (count_inc >= TIMEOUT_C) begin
          state_d       = REPORT;
          res_timeout_d = 1'b1;
          res_cycles_d  = TIMEOUT_C;
        end
      end
      // A timed-out CPU is reset again before the next program is started.
      REPORT: begin
        if (prog_idx_q == last_q) begin
          state_d = DONE;
        end else begin
          prog_idx_d = prog_idx_q + PROG_W'(1);
          tmr_load   = 1'b1;
          if (res_timeout_q) begin
            state_d = RST;
            tmr_val = RST_LD;
          end else begin
            state_d = START;
            tmr_val = START_LD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cpu_reset_d = (state_d == RST);
    cpu_start_d = (state_d == START);
    done_d      = (state_d == DONE);
    res_valid_d = (state_d == REPORT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      last_q        <= '0;
      prog_idx_q    <= '0;
      res_cycles_q  <= '0;
      res_timeout_q <= 1'b0;
      cpu_reset_q   <= 1'b0;
      cpu_start_q   <= 1'b0;
      done_q        <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      last_q        <= last_d;
      prog_idx_q    <= prog_idx_d;
      res_cycles_q  <= res_cycles_d;
      res_timeout_q <= res_timeout_d;
      cpu_reset_q   <= cpu_reset_d;
      cpu_start_q   <= cpu_start_d;
      done_q        <= done_d;
      res_valid_q   <= res_valid_d;
    end
  end

  assign CpuReset   = cpu_reset_q;
  assign CpuStart   = cpu_start_q;
  assign ProgIdx    = prog_idx_q;
  assign Busy       = (state_q != IDLE) && (state_q != DONE);
  assign Done       = done_q;
  assign ResValid   = res_valid_q;
  assign ResCycles  = res_cycles_q;
  assign ResTimeout = res_timeout_q;
  assign DbgState   = state_q;
endmodule

// File: tb/tb_prog_launcher.sv
// Randomized scoreboard bench for prog_launcher with a behavioural CPU model.
module tb_prog_launcher;
  import launcher_pkg::*;

  localparam int PW = 2;
  localparam int CW = 16;
  localparam int T  = 20;
  localparam int EW = PW + 1 + CW + 4 + 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Go = 1'b0;
  logic [PW-1:0] LastProg = '0;
  logic          Ack = 1'b1;
  logic          CpuReset, CpuStart, Busy, Done, ResValid, ResTimeout;
  logic [PW-1:0] ProgIdx;
  logic [CW-1:0] ResCycles;
  logic [2:0]    DbgState;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  // CPU model: after CpuStart falls, Ack stays high d1 cycles, low d2 cycles, then high.
  int d1_a[4];
  int d2_a[4];

  prog_launcher #(
    .PROG_W(PW), .CNT_W(CW), .RST_CYC(2), .START_CYC(1), .TIMEOUT(T)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go), .LastProg(LastProg), .Ack(Ack),
    .CpuReset(CpuReset), .CpuStart(CpuStart), .ProgIdx(ProgIdx), .Busy(Busy),
    .Done(Done), .ResValid(ResValid), .ResCycles(ResCycles),
    .ResTimeout(ResTimeout), .DbgState(DbgState)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference result for one program, from the delay profile alone.
  function automatic logic [EW-1:0] model(input int i, input bit prev_to, output bit to);
    int cyc, total, rst;
    rst = (i == 0 || prev_to) ? 2 : 0;
    total = d1_a[i] + 1 + d2_a[i];
    if (d1_a[i] >= T || total > T) begin
      to = 1'b1;
      cyc = T;
    end else begin
      to = 1'b0;
      cyc = total;
    end
    return {PW'(i), to, CW'(cyc), 4'(rst), 4'd1};
  endfunction

  // CPU model process
  initial begin
    bit start_prev = 1'b0;
    bit active = 1'b0;
    int t = 0;
    int cur = 0;
    forever begin
      @(negedge Clk);
      if (CpuReset) begin
        active = 1'b0;
        Ack = 1'b1;
      end else begin
        if (start_prev && !CpuStart) begin
          active = 1'b1;
          t = 0;
          cur = int'(ProgIdx);
        end
        if (active) begin
          Ack = !(t >= d1_a[cur] && t < d1_a[cur] + d2_a[cur]);
          t++;
        end
      end
      start_prev = CpuStart;
    end
  end

  // Monitor: counts launch pulses and checks every result against the scoreboard.
  initial begin
    int rst_cnt = 0;
    int st_cnt = 0;
    logic [EW-1:0] act, exp;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        rst_cnt = 0;
        st_cnt = 0;
      end else begin
        if (CpuReset) rst_cnt++;
        if (CpuStart) st_cnt++;
        if (ResValid) begin
          act = {ProgIdx, ResTimeout, ResCycles, 4'(rst_cnt), 4'(st_cnt)};
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL result_unexpected: got idx=%0d to=%0d cyc=%0d with empty queue",
                     ProgIdx, ResTimeout, ResCycles);
          end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
              failures++;
              $display("FAIL result: got idx=%0d to=%0d cyc=%0d rst=%0d st=%0d expected idx=%0d to=%0d cyc=%0d rst=%0d st=%0d",
                       act[EW-1 -: PW], act[CW+8], act[CW+7:8], act[7:4], act[3:0],
                       exp[EW-1 -: PW], exp[CW+8], exp[CW+7:8], exp[7:4], exp[3:0]);
            end
          end
          rst_cnt = 0;
          st_cnt = 0;
        end
      end
    end
  end

  task automatic run_batch(input int last);
    bit prev_to = 1'b0;
    bit to;
    int n;
    for (int i = 0; i <= last; i++) begin
      exp_q.push_back(model(i, prev_to, to));
      prev_to = to;
    end
    @(negedge Clk);
    Go = 1'b1;
    LastProg = PW'(last);
    @(negedge Clk);
    Go = 1'b0;
    check("go_clears_done", {31'd0, Done}, 32'd0);
    check("go_sets_busy", {31'd0, Busy}, 32'd1);
    n = 0;
    while (!Done && n < 3000) begin
      @(negedge Clk);
      Go = Busy && ($urandom_range(0, 3) == 0);
      LastProg = PW'($urandom_range(0, 3));
      n++;
    end
    Go = 1'b0;
    check("done_reached", {31'd0, Done}, 32'd1);
    check("done_not_busy", {31'd0, Busy}, 32'd0);
    check("done_prog_idx", 32'(ProgIdx), 32'(last));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  function automatic void rand_prog(input int i);
    int d1;
    do d1 = $urandom_range(0, 24); while (d1 == T - 1);
    d1_a[i] = d1;
    d2_a[i] = ($urandom_range(0, 5) == 0) ? 1000 : $urandom_range(1, 18);
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      d1_a[i] = 0;
      d2_a[i] = 1;
    end
    repeat (3) @(negedge Clk);
    check("rst_state", 32'(DbgState), 32'(IDLE));
    check("rst_outputs", {22'd0, CpuReset, CpuStart, Busy, Done, ResValid, ResTimeout, ProgIdx, 2'b0}, 32'd0);
    Reset = 1'b0;

    // Single program, 7-cycle run.
    d1_a[0] = 1; d2_a[0] = 5;
    run_batch(0);

    // Three normal programs.
    for (int i = 0; i < 3; i++) begin
      d1_a[i] = i; d2_a[i] = 3 + i;
    end
    run_batch(2);

    // Program 1 never halts again -> RUN timeout and recovery reset.
    d1_a[0] = 2; d2_a[0] = 4;
    d1_a[1] = 3; d2_a[1] = 1000;
    d1_a[2] = 0; d2_a[2] = 6;
    run_batch(2);

    // ARM timeout, Ack exactly at the limit, one past the limit.
    d1_a[0] = 40; d2_a[0] = 1;
    run_batch(0);
    d1_a[0] = 4; d2_a[0] = 15;
    run_batch(0);
    d1_a[0] = 4; d2_a[0] = 16;
    run_batch(0);

    // Largest batch.
    for (int i = 0; i < 4; i++) rand_prog(i);
    run_batch(3);

    // Reset while program 1 is in RUN.
    d1_a[0] = 1; d2_a[0] = 3;
    d1_a[1] = 2; d2_a[1] = 1000;
    exp_q.push_back({PW'(0), 1'b0, CW'(5), 4'd2, 4'd1});
    @(negedge Clk);
    Go = 1'b1;
    LastProg = 2'd3;
    @(negedge Clk);
    Go = 1'b0;
    n = 0;
    while (!(DbgState == RUN && ProgIdx == 2'd1) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("reached_run_prog1", {31'd0, (DbgState == RUN && ProgIdx == 2'd1)}, 32'd1);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("midrun_rst_state", 32'(DbgState), 32'(IDLE));
    check("midrun_rst_ctrl", {28'd0, CpuReset, CpuStart, Busy, Done}, 32'd0);
    check("midrun_rst_res", {13'd0, ResValid, ResTimeout, ResCycles, 1'b0}, 32'd0);
    check("midrun_rst_idx", 32'(ProgIdx), 32'd0);
    check("midrun_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    Reset = 1'b0;

    // Random batches.
    for (int b = 0; b < 15; b++) begin
      for (int i = 0; i < 4; i++) rand_prog(i);
      run_batch($urandom_range(0, 3));
    end

    repeat (5) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
